// File: rtl/deadtime_gen_pkg.sv
// Shared types and constants for the three-phase dead-time generator.
package deadtime_gen_pkg;

  // Width of the per-leg dead-time counter; covers DT up to 65535.
  localparam int DT_W = 16;

  // Per-leg gate state. Only UP_ON drives the upper gate, only LO_ON the lower.
  typedef enum logic [1:0] {
    OFF   = 2'd0,
    DEAD  = 2'd1,
    UP_ON = 2'd2,
    LO_ON = 2'd3
  } leg_state_e;

endpackage

// File: rtl/deadtime_leg.sv
// One half-bridge leg: FSM, dead-time counter and registered gate drives.
// The gates are registered together with the state, so a gate is high
// exactly while the FSM sits in the matching on-state. The two gates can
// never be high together.
module deadtime_leg
  import deadtime_gen_pkg::*;
#(
  parameter int DT = 100
) (
  input  logic clk,
  input  logic res,
  input  logic run,   // low: go to OFF now (enable low, fault latched or setting)
  input  logic cmd,   // registered upper-switch command
  output logic gu,
  output logic gl
);

  localparam logic [DT_W-1:0] DT_LOAD = DT_W'(DT - 1);

  // Visible for checkers: current leg state and remaining dead-time count.
  leg_state_e      state;
  logic [DT_W-1:0] cnt;

  // Leg FSM. The gates default to low, and each on-state re-asserts its own gate.
  always_ff @(posedge clk) begin
    if (res || !run) begin
      state <= OFF;
      cnt   <= '0;
      gu    <= 1'b0;
      gl    <= 1'b0;
    end else begin
      gu <= 1'b0;
      gl <= 1'b0;
      case (state)
        OFF: begin
          state <= DEAD;
          cnt   <= DT_LOAD;
        end
        DEAD: begin
          // Count runs to zero and is never restarted by cmd changes;
          // the on-state is picked from cmd at expiry.
          if (cnt == '0) begin
            if (cmd) begin
              state <= UP_ON;
              gu    <= 1'b1;
            end else begin
              state <= LO_ON;
              gl    <= 1'b1;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        UP_ON: begin
          if (!cmd) begin
            state <= DEAD;
            cnt   <= DT_LOAD;
          end else begin
            gu <= 1'b1;
          end
        end
        LO_ON: begin
          if (cmd) begin
            state <= DEAD;
            cnt   <= DT_LOAD;
          end else begin
            gl <= 1'b1;
          end
        end
        default: begin
          state <= OFF;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/deadtime_gen.sv
// Three-phase dead-time generator: samples the complementary PWM commands,
// latches a fault on any leg commanding both switches identically, and
// drives three dead-time legs.
module deadtime_gen
  import deadtime_gen_pkg::*;
#(
  parameter int DT = 100
) (
  input  logic clk,
  input  logic res,
  input  logic en,
  input  logic fault_clr,
  input  logic Sau,
  input  logic Sal,
  input  logic Sbu,
  input  logic Sbl,
  input  logic Scu,
  input  logic Scl,
  output logic gau,
  output logic gal,
  output logic gbu,
  output logic gbl,
  output logic gcu,
  output logic gcl,
  output logic fault
);

  // Sampled commands, ordered {Sau, Sal, Sbu, Sbl, Scu, Scl}.
  logic [5:0] s_q;
  logic       any_eq;
  logic       fault_set;
  logic       run;

  // Sample stage: every decision works on registered commands.
  always_ff @(posedge clk) begin
    if (res) s_q <= '0;
    else     s_q <= {Sau, Sal, Sbu, Sbl, Scu, Scl};
  end

  // Equal upper/lower commands on any leg are a shoot-through request.
  always_comb begin
    any_eq    = (s_q[5] == s_q[4]) || (s_q[3] == s_q[2]) || (s_q[1] == s_q[0]);
    fault_set = en && any_eq;
    // Legs drop to OFF on the same edge the fault sets.
    run       = en && !fault && !fault_set;
  end

  // Fault latch: clearable only while the gates are disabled.
  always_ff @(posedge clk) begin
    if (res)                    fault <= 1'b0;
    else if (fault_set)         fault <= 1'b1;
    else if (!en && fault_clr)  fault <= 1'b0;
  end

  deadtime_leg #(.DT(DT)) u_leg_a (
    .clk (clk), .res (res), .run (run), .cmd (s_q[5]), .gu (gau), .gl (gal)
  );

  deadtime_leg #(.DT(DT)) u_leg_b (
    .clk (clk), .res (res), .run (run), .cmd (s_q[3]), .gu (gbu), .gl (gbl)
  );

  deadtime_leg #(.DT(DT)) u_leg_c (
    .clk (clk), .res (res), .run (run), .cmd (s_q[1]), .gu (gcu), .gl (gcl)
  );

endmodule

// File: tb/tb_deadtime_gen.sv
// Bench for deadtime_gen: a directed per-cycle table on a DT=4 instance,
// hand sequences on a DT=100 instance, and random complementary stimulus
// across DT=1..8 watching for any upper/lower overlap.
module tb_deadtime_gen;
  import deadtime_gen_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       res = 1'b1;
  logic       en = 1'b0;
  logic       fault_clr = 1'b0;
  logic [5:0] s = 6'b000000;   // {Sau, Sal, Sbu, Sbl, Scu, Scl}

  // ---------------- DUTs ----------------
  logic [5:0] gv [1:8];        // {gau, gal, gbu, gbl, gcu, gcl}
  logic       fv [1:8];

  for (genvar i = 1; i <= 8; i++) begin : g_dt
    logic [5:0] g;
    logic       f;
    deadtime_gen #(.DT(i)) u_dut (
      .clk (clk), .res (res), .en (en), .fault_clr (fault_clr),
      .Sau (s[5]), .Sal (s[4]), .Sbu (s[3]), .Sbl (s[2]), .Scu (s[1]), .Scl (s[0]),
      .gau (g[5]), .gal (g[4]), .gbu (g[3]), .gbl (g[2]), .gcu (g[1]), .gcl (g[0]),
      .fault (f)
    );
    assign gv[i] = g;
    assign fv[i] = f;
  end

  logic [5:0] g100;
  logic       f100;
  deadtime_gen #(.DT(100)) dut100 (
    .clk (clk), .res (res), .en (en), .fault_clr (fault_clr),
    .Sau (s[5]), .Sal (s[4]), .Sbu (s[3]), .Sbl (s[2]), .Scu (s[1]), .Scl (s[0]),
    .gau (g100[5]), .gal (g100[4]), .gbu (g100[3]), .gbl (g100[2]),
    .gcu (g100[1]), .gcl (g100[0]),
    .fault (f100)
  );

  // ---------------- scoreboard ----------------
  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp)
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    else
      pass_cnt++;
  endtask

  // ---------------- driver ----------------
  task automatic drive(input logic r, input logic e, input logic c, input logic [5:0] sv);
    @(negedge clk);
    res = r;
    en = e;
    fault_clr = c;
    s = sv;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- overlap monitor ----------------
  logic mon_on = 1'b0;
  int   ov_cnt [1:8];
  int   on_cnt [1:8];

  always @(negedge clk) begin
    if (mon_on) begin
      for (int i = 1; i <= 8; i++) begin
        if ((gv[i][5] & gv[i][4]) | (gv[i][3] & gv[i][2]) | (gv[i][1] & gv[i][0]))
          ov_cnt[i]++;
        if (gv[i] != 6'b0) on_cnt[i]++;
      end
    end
  end

  // ---------------- directed table (DT = 4) ----------------
  typedef struct {
    logic       en;
    logic       clr;
    logic [5:0] s;
    logic [5:0] g;   // expected gates after the edge
    logic       f;   // expected fault after the edge
  } vec_t;

  localparam int NV = 37;
  vec_t tbl [NV];

  function automatic vec_t mk(input logic e, input logic c, input logic [5:0] sv,
                              input logic [5:0] gx, input logic fx);
    vec_t v;
    v.en = e; v.clr = c; v.s = sv; v.g = gx; v.f = fx;
    return v;
  endfunction

  localparam logic [5:0] ALL_UP = 6'b101010;
  localparam logic [5:0] A_LO   = 6'b011010;
  localparam logic [5:0] B_BAD  = 6'b101110;

  initial begin
    for (int i = 1; i <= 8; i++) begin
      ov_cnt[i] = 0;
      on_cnt[i] = 0;
    end

    // Row k: inputs sampled at edge k; expected outputs right after edge k.
    tbl[0]  = mk(0, 0, ALL_UP, 6'b000000, 0);  // load sample regs
    tbl[1]  = mk(1, 0, ALL_UP, 6'b000000, 0);  // OFF -> DEAD cnt 3
    tbl[2]  = mk(1, 0, ALL_UP, 6'b000000, 0);
    tbl[3]  = mk(1, 0, ALL_UP, 6'b000000, 0);
    tbl[4]  = mk(1, 0, ALL_UP, 6'b000000, 0);
    tbl[5]  = mk(1, 0, ALL_UP, 6'b101010, 0);  // upper gates rise 4 after DEAD entry
    tbl[6]  = mk(1, 0, A_LO,   6'b101010, 0);  // leg a flips, sampled at N=6
    tbl[7]  = mk(1, 0, A_LO,   6'b001010, 0);  // gau falls at N+1
    tbl[8]  = mk(1, 0, A_LO,   6'b001010, 0);
    tbl[9]  = mk(1, 0, A_LO,   6'b001010, 0);
    tbl[10] = mk(1, 0, A_LO,   6'b001010, 0);
    tbl[11] = mk(1, 0, A_LO,   6'b011010, 0);  // gal rises at N+5
    tbl[12] = mk(1, 0, ALL_UP, 6'b011010, 0);
    tbl[13] = mk(1, 0, ALL_UP, 6'b001010, 0);
    tbl[14] = mk(1, 0, ALL_UP, 6'b001010, 0);
    tbl[15] = mk(1, 0, ALL_UP, 6'b001010, 0);
    tbl[16] = mk(1, 0, ALL_UP, 6'b001010, 0);
    tbl[17] = mk(1, 0, ALL_UP, 6'b101010, 0);  // leg a back in UP_ON
    tbl[18] = mk(1, 0, A_LO,   6'b101010, 0);  // 2-cycle low pulse starts
    tbl[19] = mk(1, 0, A_LO,   6'b001010, 0);
    tbl[20] = mk(1, 0, ALL_UP, 6'b001010, 0);  // cmd returns during DEAD
    tbl[21] = mk(1, 0, ALL_UP, 6'b001010, 0);
    tbl[22] = mk(1, 0, ALL_UP, 6'b001010, 0);
    tbl[23] = mk(1, 0, ALL_UP, 6'b101010, 0);  // expiry picks upper, gal never rose
    tbl[24] = mk(1, 0, B_BAD,  6'b101010, 0);  // Sbu=Sbl=1 sampled
    tbl[25] = mk(1, 0, ALL_UP, 6'b000000, 1);  // fault and all off next edge
    tbl[26] = mk(1, 1, ALL_UP, 6'b000000, 1);  // clear ignored while enabled
    tbl[27] = mk(0, 0, ALL_UP, 6'b000000, 1);
    tbl[28] = mk(0, 1, ALL_UP, 6'b000000, 0);  // clear while disabled
    tbl[29] = mk(0, 0, ALL_UP, 6'b000000, 0);
    tbl[30] = mk(1, 0, ALL_UP, 6'b000000, 0);  // restart through DEAD
    tbl[31] = mk(1, 0, ALL_UP, 6'b000000, 0);
    tbl[32] = mk(1, 0, ALL_UP, 6'b000000, 0);
    tbl[33] = mk(1, 0, ALL_UP, 6'b000000, 0);
    tbl[34] = mk(1, 0, ALL_UP, 6'b101010, 0);
    tbl[35] = mk(0, 0, ALL_UP, 6'b000000, 0);  // enable low drops gates at once
    tbl[36] = mk(0, 0, ALL_UP, 6'b000000, 0);

    // ---- reset state ----
    drive(1, 0, 0, 6'b000000);
    step();
    drive(1, 0, 0, 6'b000000);
    step();
    chk("reset_gates_dt4", {26'd0, gv[4]}, 32'd0);
    chk("reset_fault_dt4", {31'd0, fv[4]}, 32'd0);
    chk("reset_gates_dt100", {26'd0, g100}, 32'd0);
    chk("reset_cnt_dt100", {16'd0, dut100.u_leg_a.cnt}, 32'd0);
    chk("reset_state_dt100", {30'd0, dut100.u_leg_a.state}, {30'd0, OFF});

    // ---- table ----
    for (int k = 0; k < NV; k++) begin
      drive(0, tbl[k].en, tbl[k].clr, tbl[k].s);
      step();
      chk($sformatf("tbl%0d_gates", k), {26'd0, gv[4]}, {26'd0, tbl[k].g});
      chk($sformatf("tbl%0d_fault", k), {31'd0, fv[4]}, {31'd0, tbl[k].f});
    end

    // ---- DT=100: reset mid-DEAD at count 50, DT=4 is mid-ON at that time ----
    drive(0, 1, 0, ALL_UP);
    step();
    chk("dt100_dead_entry_cnt", {16'd0, dut100.u_leg_a.cnt}, 32'd99);
    for (int k = 0; k < 49; k++) begin
      drive(0, 1, 0, ALL_UP);
      step();
    end
    chk("dt100_mid_cnt", {16'd0, dut100.u_leg_a.cnt}, 32'd50);
    chk("dt4_on_before_res", {26'd0, gv[4]}, {26'd0, ALL_UP});
    drive(1, 1, 0, ALL_UP);
    step();
    chk("res_mid_dead_gates", {26'd0, g100}, 32'd0);
    chk("res_mid_dead_fault", {31'd0, f100}, 32'd0);
    chk("res_mid_dead_cnt", {16'd0, dut100.u_leg_a.cnt}, 32'd0);
    chk("res_mid_dead_state", {30'd0, dut100.u_leg_a.state}, {30'd0, OFF});
    chk("res_mid_on_gates_dt4", {26'd0, gv[4]}, 32'd0);
    drive(0, 0, 0, ALL_UP);
    step();
    chk("post_res_gates_low", {26'd0, g100}, 32'd0);
    drive(0, 1, 0, ALL_UP);
    step();
    chk("restart_cnt_99", {16'd0, dut100.u_leg_a.cnt}, 32'd99);
    for (int k = 0; k < 99; k++) begin
      drive(0, 1, 0, ALL_UP);
      step();
    end
    chk("dt100_last_dead_gates", {26'd0, g100}, 32'd0);
    drive(0, 1, 0, ALL_UP);
    step();
    chk("dt100_gates_rise", {26'd0, g100}, {26'd0, ALL_UP});

    // ---- random complementary stimulus across DT=1..8 ----
    drive(1, 0, 0, 6'b000000);
    step();
    drive(0, 0, 0, ALL_UP);
    step();
    mon_on = 1'b1;
    begin
      int         hold [3];
      logic [2:0] up;
      logic       e;
      up = 3'b111;
      for (int l = 0; l < 3; l++) hold[l] = 0;
      for (int c = 0; c < 3000; c++) begin
        for (int l = 0; l < 3; l++) begin
          if (hold[l] == 0) begin
            up[l]   = 1'($urandom_range(0, 1));
            hold[l] = $urandom_range(1, 12);
          end else begin
            hold[l]--;
          end
        end
        e = ($urandom_range(0, 63) != 0);
        drive(0, e, 0, {up[2], ~up[2], up[1], ~up[1], up[0], ~up[0]});
        step();
      end
    end
    @(negedge clk);
    mon_on = 1'b0;
    for (int i = 1; i <= 8; i++)
      chk($sformatf("rand_overlap_dt%0d", i), ov_cnt[i], 32'd0);
    chk("rand_gates_active_dt8", {31'd0, on_cnt[8] > 100}, 32'd1);
    chk("rand_no_fault_dt8", {31'd0, fv[8]}, 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/deadtime_gen.md
DEADTIME_GEN -- requirements
Module: deadtime_gen

Interface
REQ-001 The block SHALL have parameter DT, default 100, meaning dead time in clk cycles (1 us at 100 MHz); legal range 1..65535.
REQ-002 The block SHALL have port clk, input, 1, single system clock.
REQ-003 The block SHALL have port res, input, 1, reset; synchronous and active-high.
REQ-004 The block SHALL have port en, input, 1, gate enable; low forces all gates off.
REQ-005 The block SHALL have port fault_clr, input, 1, clears latched fault when en is low.
REQ-006 The block SHALL have ports Sau, Sal, Sbu, Sbl, Scu, Scl, input, 1 each, complementary switch commands from the upstream PWM comparator.
REQ-007 The block SHALL have ports gau, gal, gbu, gbl, gcu, gcl, output, 1 each, gate drives with dead time applied.
REQ-008 The block SHALL have port fault, output, 1, latched shoot-through-command fault.

Function
REQ-009 The block SHALL register all six S inputs once (sample stage) before any decision; the leg command SHALL be cmd = registered Sxu.
REQ-010 Each leg SHALL run an independent FSM with states OFF, DEAD, UP_ON, LO_ON; the upper gate SHALL be high only in UP_ON and the lower gate only in LO_ON.
REQ-011 All gate outputs SHALL be registered; an upper gate and a lower gate of the same leg SHALL never be high in the same cycle.
REQ-012 From UP_ON with cmd=0, or from LO_ON with cmd=1, the FSM SHALL enter DEAD and load the leg counter with DT-1.
REQ-013 In DEAD, the counter SHALL decrement each cycle; at count 0 the FSM SHALL enter UP_ON if cmd=1, else LO_ON, giving exactly DT cycles with both gates low.
REQ-014 A cmd change during DEAD SHALL NOT restart the counter; the on-state chosen SHALL be the cmd value at expiry.
REQ-015 Latency: for an input edge sampled at clock edge N, the old gate SHALL fall at edge N+1 and the new gate SHALL rise at edge N+1+DT.
REQ-016 From OFF, when en=1 and fault=0, the FSM SHALL enter DEAD (counter DT-1) before any gate turns on.
REQ-017 When en=0, every leg SHALL enter OFF on the next edge regardless of state, with counters cleared.
REQ-018 When en=1 and any leg has registered Sxu equal to registered Sxl, fault SHALL set on the next edge and all legs SHALL enter OFF on that same edge.
REQ-019 While fault=1, all legs SHALL stay OFF irrespective of en or inputs.
REQ-020 fault SHALL clear only on res, or on fault_clr=1 while en=0; fault_clr while en=1 SHALL be ignored.
REQ-021 Upstream PWM pulses shorter than DT SHALL be absorbed, with both gates held low; there SHALL be no minimum-on enforcement beyond this.

Reset
REQ-022 On res=1 at a clock edge, all gates SHALL be 0, fault 0, all FSMs OFF, counters 0, and input sample registers 0.
REQ-023 Reset asserted mid-DEAD or mid-ON SHALL take effect on that edge with no gate glitch high.
REQ-024 After res is released, gates SHALL remain low until en=1 and the DEAD interval of REQ-016 has elapsed.

Structure
REQ-025 A shared package SHALL hold the leg state enum (OFF, DEAD, UP_ON, LO_ON) and the constant DT_W = 16 for counter width.
REQ-026 A sub-module deadtime_leg (FSM, counter, gate registers) SHALL be instantiated three times; deadtime_gen SHALL own the input sample stage, fault latch and enable fan-out.

Verification
REQ-027 Reset then en=1 with Sau=1, Sal=0 and DT=4: gau SHALL rise 4 cycles after DEAD entry, and gal SHALL stay 0.
REQ-028 With DT=4 and leg a in UP_ON, Sau 1->0 and Sal 0->1 sampled at edge N: gau=0 at N+1, gal=1 at N+5, with gau=gal=0 for exactly 4 cycles.
REQ-029 With DT=4, a 2-cycle Sau=0 pulse in UP_ON: both gates SHALL be low for 4 cycles, then gau=1 (cmd back to 1 at expiry), and gal SHALL never rise.
REQ-030 With en=1, force Sbu=Sbl=1 for 1 cycle: fault=1 and all six gates 0 on the next edge; fault_clr with en=1 SHALL leave fault=1; en=0 then fault_clr=1 SHALL give fault=0.
REQ-031 Assert res mid-DEAD with DT=100 at count 50: all outputs SHALL be 0 on that edge and the count SHALL restart from 99 after en=1.
REQ-032 A random-stimulus check across all DT values 1..8 SHALL assert that gxu&gxl is never 1 for any leg.
